hart_fetch_unit: RTL
====================

# hart_fetch_unit

Parametrised multi-hart instruction fetch stage for the FMRT core. It holds one PC per hart, picks an issuing hart each cycle, reads instructions from the synchronous SPM, and loads the IF/ID pipeline register. Redirects are applied per hart: flush, cache miss, branch, hart start and hart idle. Only the affected hart's in-flight instruction is squashed.

## Interface
- HART_NUM, 4 — number of harts; must be a power of 2, ≥2.
- HART_ID_W, $clog2(HART_NUM) — hart-id width.
- RESET_PC, 32'h0 — reset PC of hart 0.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- spm_rd_data  in  32  SPM read data; valid the cycle after the address.
- spm_addr  out  30  word address (pc[31:2]).
- spm_as_  out  1  strobe, active-low.
- spm_rw  out  1  constant READ.
- spm_wr_data  out  32  constant 0.
- stall  in  1  freeze the fetch pipeline.
- flush  in  1  global squash.
- fl_hart_id  in  HART_ID_W  hart that receives new_pc.
- new_pc  in  32  flush target.
- cache_miss  in  1  miss report.
- cm_hart_id  in  HART_ID_W  hart that missed.
- cm_addr  in  32  replay PC.
- cm_clear  in  1  miss serviced.
- cm_clear_id  in  HART_ID_W  hart whose miss is serviced.
- br_taken  in  1  branch taken.
- br_hart_id  in  HART_ID_W  branch hart; also the hart currently in ID.
- br_addr  in  32  branch target.
- hart_id  in  HART_ID_W  external issue select; used only when IF_HART_RR_EN is undefined.
- id_hstart  in  1  start a hart.
- id_hs_id  in  HART_ID_W  hart to start.
- id_hs_pc  in  32  start PC.
- id_hidle  in  1  put hart br_hart_id into IDLE.
- pc  out  32  PC of the F1 entry.
- if_pc  out  32  IF/ID next PC (fetched pc+4).
- if_insn  out  32  IF/ID instruction.
- if_en  out  1  IF/ID valid.
- if_hart_id  out  HART_ID_W  IF/ID hart.

## Operation
- Per-hart state is IDLE, ACTIVE or PEND. Only ACTIVE harts are eligible to issue.
- Reset values:
  - hart 0 is ACTIVE with pc_table = RESET_PC; all other harts are IDLE with pc_table = 0.
  - F1 valid = 0; rr pointer = HART_NUM-1.
  - if_en = 0, if_pc = 0, if_insn = 0 (NOP), if_hart_id = 0, pc = 0.
- Issue (F0, not stalled, an eligible hart h exists):
  - spm_as_ = 0, spm_addr = pc_table[h][31:2].
  - At the edge: pc_table[h] += 4; F1 <= {h, pc, valid=1}.
  - If no hart is eligible: spm_as_ = 1 and F1 valid <= 0.
- Capture (F1, not stalled): at the edge the IF/ID register loads:
  - if_insn = spm_rd_data
  - if_pc = F1.pc + 4
  - if_hart_id = F1.hart
  - if_en = F1.valid after squash
- Redirect priority for a single hart: flush > cache_miss > br_taken > id_hstart > id_hidle > increment.
  - flush: every F1 entry is squashed; pc_table[fl_hart_id] <= new_pc.
  - cache_miss: pc_table[cm] <= cm_addr; state PEND. PEND→ACTIVE on cm_clear for that hart. cm_clear and cache_miss for the same hart in the same cycle → PEND wins.
  - br_taken: pc_table[br] <= br_addr.
  - id_hstart: state ACTIVE; pc <= id_hs_pc. Ignored if the hart is PEND.
  - id_hidle: hart br_hart_id → IDLE.
- Squash rule: an entry for hart x is invalid if x receives any redirect in that cycle. This applies both to the entry leaving F1 into IF/ID and to the entry entering F1. A redirected hart's PC takes the redirect value and is not incremented.
- Different harts can be redirected in the same cycle; each update is applied independently.
- Round robin (IF_HART_RR_EN): search starts at rr+1 modulo HART_NUM and takes the first ACTIVE hart; rr <= that hart when it issues.
- IF/ID entries carry no branch prediction; branch resolution is external.

## Timing
- Fetch latency: address driven in cycle N; IF/ID output valid in cycle N+2 (one F1 cycle plus the capture edge).
- Throughput is one instruction per cycle while any hart is ACTIVE.
- Stall:
  - F1, IF/ID, rr and the PC increment all hold.
  - spm_addr re-drives F1.pc with spm_as_ = 0 if F1 is valid, so rd_data stays valid for the held entry.
  - Redirects still update pc_table and hart state, and still clear F1 valid.
- Reset mid-operation forces all reset values immediately (asynchronous).
- Writing the PC wraps modulo 2^32; bits [1:0] of every PC are forced to 0.

## Configuration
- IF_HART_RR_EN defined: the internal round-robin scheduler is used and the hart_id input is ignored.
- IF_HART_RR_EN undefined: the issuing hart is hart_id if that hart is ACTIVE; otherwise there is no issue. rr logic is not built.

## Structure
- Shared package (hart_ctrl.h / base_core_defines.v):
  - hart-state encodings: IDLE 2'b00, ACTIVE 2'b01, PEND 2'b10
  - HART_ID_B width macro
  - RESET_PC default
  - NOP encoding
- Sub-module hart_rr_arbiter: a HART_NUM-bit eligible mask plus the rr pointer in, grant id and grant-valid out.

## Test plan
- Reset release, HART_NUM=4, SPM word k = k → if_en first rises in cycle 2; hart 0 shows pc 0, 4, 8… with if_insn 0, 1, 2.
- id_hstart hart 2 at pc 0x100 → IF/ID alternates harts 0 and 2, and hart 2's if_pc runs 0x104, 0x108….
- br_taken for hart 2 to 0x200 while hart 2's entry is in F1 → that entry arrives with if_en=0; hart 2's next fetch is 0x200; hart 0 is unaffected.
- cache_miss for hart 0 with cm_addr 0x40 → hart 0 stops issuing; after cm_clear the next hart 0 pc is 0x40.
- stall held 3 cycles mid-stream → IF/ID and pc are unchanged for 3 cycles; on release the sequence resumes with no loss or duplication.
- flush with fl_hart_id 0 and new_pc 0x80 in the same cycle as br_taken for hart 0 to 0x300 → hart 0 resumes at 0x80 and all in-flight entries are invalid.

Source files
------------

// File: rtl/hart_fetch_unit_pkg.sv
// rtl/hart_fetch_unit_pkg.sv - shared hart-state encodings and fetch constants
package hart_fetch_unit_pkg;

  typedef enum logic [1:0] {
    HS_IDLE   = 2'b00,
    HS_ACTIVE = 2'b01,
    HS_PEND   = 2'b10
  } hart_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] NOP_INSN     = 32'h0000_0000;
  localparam logic        SPM_READ     = 1'b1;

  // Hart-id width for a given hart count (at least one bit).
  function automatic int hart_id_b(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Every PC written into the table is word aligned.
  function automatic logic [31:0] pc_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

endpackage

// File: rtl/hart_fetch_unit_rr_arbiter.sv
// rtl/hart_fetch_unit_rr_arbiter.sv - picks the first eligible hart after rr_ptr
module hart_rr_arbiter
  import hart_fetch_unit_pkg::*;
#(
  parameter int HART_NUM  = 4,
  parameter int HART_ID_W = hart_id_b(HART_NUM)
) (
  input  logic [HART_NUM-1:0]  eligible,
  input  logic [HART_ID_W-1:0] rr_ptr,
  output logic [HART_ID_W-1:0] grant_id,
  output logic                 grant_valid
);

  logic [HART_ID_W-1:0] idx;

  // Walk rr_ptr+1 .. rr_ptr (wrapping by truncation, HART_NUM is a power of 2).
  always_comb begin
    grant_id    = rr_ptr;
    grant_valid = 1'b0;
    idx         = rr_ptr;
    for (int i = 1; i <= HART_NUM; i++) begin
      idx = rr_ptr + HART_ID_W'(i);
      if (!grant_valid && eligible[idx]) begin
        grant_valid = 1'b1;
        grant_id    = idx;
      end
    end
  end

endmodule

// File: rtl/hart_fetch_unit.sv
// rtl/hart_fetch_unit.sv - multi-hart fetch stage (build option IF_HART_RR_EN: internal round robin)
module hart_fetch_unit
  import hart_fetch_unit_pkg::*;
#(
  parameter int          HART_NUM  = 4,
  parameter int          HART_ID_W = hart_id_b(HART_NUM),
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          spm_rd_data,
  output logic [29:0]          spm_addr,
  output logic                 spm_as_,
  output logic                 spm_rw,
  output logic [31:0]          spm_wr_data,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [HART_ID_W-1:0] fl_hart_id,
  input  logic [31:0]          new_pc,
  input  logic                 cache_miss,
  input  logic [HART_ID_W-1:0] cm_hart_id,
  input  logic [31:0]          cm_addr,
  input  logic                 cm_clear,
  input  logic [HART_ID_W-1:0] cm_clear_id,
  input  logic                 br_taken,
  input  logic [HART_ID_W-1:0] br_hart_id,
  input  logic [31:0]          br_addr,
  input  logic [HART_ID_W-1:0] hart_id,
  input  logic                 id_hstart,
  input  logic [HART_ID_W-1:0] id_hs_id,
  input  logic [31:0]          id_hs_pc,
  input  logic                 id_hidle,
  output logic [31:0]          pc,
  output logic [31:0]          if_pc,
  output logic [31:0]          if_insn,
  output logic                 if_en,
  output logic [HART_ID_W-1:0] if_hart_id
);

  hart_state_e          st       [HART_NUM];
  logic [31:0]          pc_table [HART_NUM];
  logic                 f1_valid;
  logic [HART_ID_W-1:0] f1_hart;
  logic [31:0]          f1_pc;

  logic [HART_NUM-1:0]  fl_hit, cm_hit, br_hit, hs_hit, hi_hit, clr_hit;
  logic [HART_NUM-1:0]  redir, active_mask;
  logic [HART_ID_W-1:0] sel_id;
  logic                 sel_valid;
  logic                 issue;
  logic                 f1_in_valid;

  assign spm_rw      = SPM_READ;
  assign spm_wr_data = 32'h0;
  assign pc          = f1_pc;

  // Decode every redirect source into per-hart hit vectors.
  always_comb begin
    for (int h = 0; h < HART_NUM; h++) begin
      fl_hit[h]      = flush      && (fl_hart_id  == HART_ID_W'(h));
      cm_hit[h]      = cache_miss && (cm_hart_id  == HART_ID_W'(h));
      br_hit[h]      = br_taken   && (br_hart_id  == HART_ID_W'(h));
      hs_hit[h]      = id_hstart  && (id_hs_id    == HART_ID_W'(h)) && (st[h] != HS_PEND);
      hi_hit[h]      = id_hidle   && (br_hart_id  == HART_ID_W'(h));
      clr_hit[h]     = cm_clear   && (cm_clear_id == HART_ID_W'(h)) && (st[h] == HS_PEND);
      active_mask[h] = (st[h] == HS_ACTIVE);
    end
    redir = fl_hit | cm_hit | br_hit | hs_hit | hi_hit;
  end

`ifdef IF_HART_RR_EN
  logic [HART_ID_W-1:0] rr;

  hart_rr_arbiter #(.HART_NUM(HART_NUM), .HART_ID_W(HART_ID_W)) u_arb (
    .eligible    (active_mask),
    .rr_ptr      (rr),
    .grant_id    (sel_id),
    .grant_valid (sel_valid)
  );

  // Round-robin pointer follows the hart that actually issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rr <= HART_ID_W'(HART_NUM - 1);
    else if (issue)  rr <= sel_id;
  end
`else
  // Externally selected hart: a one-hot mask makes the arbiter grant hart_id only if ACTIVE.
  hart_rr_arbiter #(.HART_NUM(HART_NUM), .HART_ID_W(HART_ID_W)) u_arb (
    .eligible    (active_mask & (HART_NUM'(1) << hart_id)),
    .rr_ptr      (hart_id - HART_ID_W'(1)),
    .grant_id    (sel_id),
    .grant_valid (sel_valid)
  );
`endif

  assign issue       = !stall && sel_valid;
  assign f1_in_valid = issue && !flush && !redir[sel_id];

  // SPM request: new fetch when running, re-drive the held F1 entry while stalled.
  always_comb begin
    if (stall) begin
      spm_addr = f1_pc[31:2];
      spm_as_  = !f1_valid;
    end else begin
      spm_addr = pc_table[sel_id][31:2];
      spm_as_  = !sel_valid;
    end
  end

  // Per-hart PC and state; redirects win over the fetch increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int h = 0; h < HART_NUM; h++) begin
        pc_table[h] <= (h == 0) ? pc_align(RESET_PC) : 32'h0;
        st[h]       <= (h == 0) ? HS_ACTIVE : HS_IDLE;
      end
    end else begin
      for (int h = 0; h < HART_NUM; h++) begin
        if (clr_hit[h]) st[h] <= HS_ACTIVE;
        if (fl_hit[h]) begin
          pc_table[h] <= pc_align(new_pc);
        end else if (cm_hit[h]) begin
          pc_table[h] <= pc_align(cm_addr);
          st[h]       <= HS_PEND;
        end else if (br_hit[h]) begin
          pc_table[h] <= pc_align(br_addr);
        end else if (hs_hit[h]) begin
          pc_table[h] <= pc_align(id_hs_pc);
          st[h]       <= HS_ACTIVE;
        end else if (hi_hit[h]) begin
          st[h]       <= HS_IDLE;
        end else if (issue && (sel_id == HART_ID_W'(h))) begin
          pc_table[h] <= pc_table[h] + 32'd4;
        end
      end
    end
  end

  // F1 stage and IF/ID register; stall holds both but redirects still kill F1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      f1_valid   <= 1'b0;
      f1_hart    <= '0;
      f1_pc      <= 32'h0;
      if_en      <= 1'b0;
      if_pc      <= 32'h0;
      if_insn    <= NOP_INSN;
      if_hart_id <= '0;
    end else if (!stall) begin
      f1_valid <= f1_in_valid;
      if (issue) begin
        f1_hart <= sel_id;
        f1_pc   <= pc_table[sel_id];
      end
      if_en      <= f1_valid && !flush && !redir[f1_hart];
      if_insn    <= spm_rd_data;
      if_pc      <= f1_pc + 32'd4;
      if_hart_id <= f1_hart;
    end else if (flush || redir[f1_hart]) begin
      f1_valid <= 1'b0;
    end
  end

endmodule
